// File: rtl/tuple_bit_serializer.sv
// tuple_bit_serializer
//   Parallel-to-serial transmitter for a Tuple(Bit) serial lane. A word taken
//   over the I_valid/I_ready handshake is shifted out LSB-first, one bit per
//   accepted beat, on O__0. O_valid/O_ready form the per-beat handshake, and
//   O_last marks the final beat of each frame.
//
//   Optional feature macro: TUPLE_BIT_SERIALIZER_PARITY_EN
//     defined   : each frame is N data beats plus one even-parity beat;
//                 O_last marks only the parity beat.
//     undefined : each frame is N data beats; O_last marks data beat N-1.
//
// Ports
//   CLK          in   rising-edge clock
//   ASYNCRESETN  in   asynchronous reset, active-low
//   I_data       in   N-bit parallel word
//   I_valid      in   I_data is valid
//   I_ready      out  word accepted this cycle (IDLE and not in reset)
//   O__0         out  serial bit, tuple field 0
//   O_valid      out  O__0 carries a valid beat
//   O_last       out  final beat of the frame
//   O_ready      in   downstream accepts the current beat
module tuple_bit_serializer #(
    parameter int unsigned N = 8
) (
    input  logic         CLK,
    input  logic         ASYNCRESETN,
    input  logic [N-1:0] I_data,
    input  logic         I_valid,
    output logic         I_ready,
    output logic         O__0,
    output logic         O_valid,
    output logic         O_last,
    input  logic         O_ready
);

    localparam int unsigned CW = $clog2(N);
    localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);

`ifdef TUPLE_BIT_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N-1:0]    r_sh;
    logic [N-1:0]    w_sh_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
`ifdef TUPLE_BIT_SERIALIZER_PARITY_EN
    logic            r_par;
    logic            w_par_nxt;
`endif
    logic            w_ready;
    logic            w_o0;
    logic            w_ovalid;
    logic            w_olast;

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            r_state <= IDLE;
            r_sh    <= '0;
            r_cnt   <= '0;
`ifdef TUPLE_BIT_SERIALIZER_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_sh    <= w_sh_nxt;
            r_cnt   <= w_cnt_nxt;
`ifdef TUPLE_BIT_SERIALIZER_PARITY_EN
            r_par   <= w_par_nxt;
`endif
        end
    end

    // Outputs are decoded from registered state only; O_ready and I_valid
    // steer next-state values but never reach an output combinationally.
    always_comb begin
        w_state_nxt = r_state;
        w_sh_nxt    = r_sh;
        w_cnt_nxt   = r_cnt;
`ifdef TUPLE_BIT_SERIALIZER_PARITY_EN
        w_par_nxt   = r_par;
`endif
        w_ready     = 1'b0;
        w_o0        = 1'b0;
        w_ovalid    = 1'b0;
        w_olast     = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (I_valid) begin
                    w_sh_nxt    = I_data;
                    w_cnt_nxt   = '0;
`ifdef TUPLE_BIT_SERIALIZER_PARITY_EN
                    w_par_nxt   = ^I_data;
`endif
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                w_ovalid = 1'b1;
                w_o0     = r_sh[0];
`ifndef TUPLE_BIT_SERIALIZER_PARITY_EN
                w_olast  = (r_cnt == LAST_BEAT);
`endif
                if (O_ready) begin
                    w_sh_nxt = r_sh >> 1;
                    if (r_cnt == LAST_BEAT) begin
                        w_cnt_nxt = '0;
`ifdef TUPLE_BIT_SERIALIZER_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_state_nxt = IDLE;
`endif
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
            end
`ifdef TUPLE_BIT_SERIALIZER_PARITY_EN
            PARITY: begin
                w_ovalid = 1'b1;
                w_o0     = r_par;
                w_olast  = 1'b1;
                if (O_ready) begin
                    w_state_nxt = IDLE;
                end
            end
`endif
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // The state register already reads IDLE during reset, so I_ready is
    // additionally gated by the reset pin to keep it low while held.
    assign I_ready = w_ready & ASYNCRESETN;
    assign O__0    = w_o0;
    assign O_valid = w_ovalid;
    assign O_last  = w_olast;

endmodule
